// File: rtl/iobus_arbiter_if.sv
// Requester-side and peripheral-side bundles for the MMIO IOBUS arbiter.
// master modports belong to the side that originates the request.
interface iobus_arbiter_if;
  logic        req;
  logic        lock;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, lock, wr, addr, wdata,
    input  gnt, ack, err, rdata
  );

  modport slave (
    input  req, lock, wr, addr, wdata,
    output gnt, ack, err, rdata
  );
endinterface

interface iobus_periph_if;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        wr;
  logic [31:0] din;

  modport master (
    output addr, dout, wr,
    input  din
  );

  modport slave (
    input  addr, dout, wr,
    output din
  );
endinterface

// File: rtl/iobus_arbiter.sv
// Two-master ARB/BUS/ACK sequencer for the board MMIO IOBUS, with LOCK.
// Define IOBUS_ARB_FIXED_PRI_EN to resolve ties to M0 instead of round-robin.
module iobus_arbiter #(
  parameter logic [31:0] IO_BASE  = 32'h1100_0000,
  parameter logic [31:0] IO_MASK  = 32'hFFFF_FF00,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           CLK,
  input  logic           RST,
  iobus_arbiter_if.slave m0,
  iobus_arbiter_if.slave m1,
  iobus_periph_if.master io
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [2:0] {
    ARB,
    BUS0,
    BUS1,
    ACK0,
    ACK1
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic          lock_q;
  logic          owner_q;
  logic [HW-1:0] hold_cnt;

  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_wr;
  logic          beat_wr;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;
  logic          err0;
  logic          err1;

  logic          owner_lock;
  logic          lock_eff;
  logic          req0;
  logic          req1;
  logic          tie_pick;
  logic          grant;
  logic          winner;
  logic          win_wr;
  logic          win_lock;
  logic          win_in;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic          bus_in;
  logic [31:0]   bus_rdata;

`ifdef IOBUS_ARB_FIXED_PRI_EN
  assign tie_pick = 1'b0;
`else
  logic last_grant;

  assign tie_pick = ~last_grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`endif

  // A live lock masks the other requester; an idle owner stalls ARB.
  always_comb begin
    owner_lock = owner_q ? m1.lock : m0.lock;
    lock_eff   = lock_q && owner_lock &&
                 (hold_cnt < HW'(MAX_HOLD));
    req0       = m0.req && !(lock_eff && owner_q);
    req1       = m1.req && !(lock_eff && !owner_q);
    winner     = 1'b0;
    unique case (1'b1)
      req0 && req1:  winner = tie_pick;
      !req0 && req1: winner = 1'b1;
      default:       winner = 1'b0;
    endcase
    grant     = (state == ARB) && (req0 || req1);
    win_wr    = winner ? m1.wr    : m0.wr;
    win_lock  = winner ? m1.lock  : m0.lock;
    win_addr  = winner ? m1.addr  : m0.addr;
    win_wdata = winner ? m1.wdata : m0.wdata;
    win_in    = (win_addr & IO_MASK) == IO_BASE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m0.gnt   = 1'b0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.gnt   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    unique case (state)
      ARB: begin
        if (grant) begin
          state_nx = winner ? BUS1 : BUS0;
        end
      end
      BUS0: begin
        m0.gnt   = 1'b1;
        state_nx = ACK0;
      end
      BUS1: begin
        m1.gnt   = 1'b1;
        state_nx = ACK1;
      end
      ACK0: begin
        m0.ack   = 1'b1;
        m0.err   = err0;
        state_nx = ARB;
      end
      ACK1: begin
        m1.ack   = 1'b1;
        m1.err   = err1;
        state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      hold_cnt <= '0;
    end else if (grant) begin
      owner_q <= winner;
      if (!win_lock) begin
        lock_q   <= 1'b0;
        hold_cnt <= '0;
      end else if (lock_eff) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        lock_q   <= 1'b1;
        hold_cnt <= HW'(1);
      end
    end else if (state == ARB && lock_q && !lock_eff) begin
      lock_q   <= 1'b0;
      hold_cnt <= '0;
    end
  end

  assign bus_in    = (bus_addr & IO_MASK) == IO_BASE;
  assign bus_rdata = (!beat_wr && bus_in) ? io.din : '0;

  // Address/data stay put after the beat so the decode never glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      beat_wr   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      bus_wr <= 1'b0;
      if (grant) begin
        bus_addr  <= win_addr;
        bus_wdata <= win_wdata;
        beat_wr   <= win_wr;
        bus_wr    <= win_wr && win_in;
      end
      if (state == BUS0) begin
        rdata0 <= bus_rdata;
        err0   <= !bus_in;
      end
      if (state == BUS1) begin
        rdata1 <= bus_rdata;
        err1   <= !bus_in;
      end
    end
  end

  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;
  assign io.addr  = bus_addr;
  assign io.dout  = bus_wdata;
  assign io.wr    = bus_wr;

endmodule
